fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the decoder: owns the PC, issues
//  word reads to instruction memory, buffers returned words with their PC and presents
//  them to decode over a valid/ready handshake. Handles branch/jump redirects by flushing
//  the buffer and discarding in-flight responses, and stops fetching on a halt request.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first fetch after reset (bits [1:0] must be 0)
//  BUF_DEPTH   2              instruction buffer entries; also max requests in flight (2..8)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst             in   1   reset, synchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address (word aligned)
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_rsp_valid  in   1   read data valid (in order, >=1 cycle after acceptance)
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   taken branch/jump from execute
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced 0)
//  halt            in   1   decoder saw halt; stop fetching
//  ir_valid        out  1   instruction available to decode
//  ir              out  32  instruction word (buffer head)
//  ir_pc           out  32  PC of ir
//  ir_ready        in   1   decode consumes head this cycle
//  halted          out  1   fetch fully stopped
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. In reset: pc<=RESET_PC, buffer empty,
//    outstanding=0, drop_cnt=0, state=RUN; imem_req_valid=0, ir_valid=0, ir=0, ir_pc=0, halted=0.
//  - States: RUN -> (halt sampled) DRAIN -> (outstanding==0) HALTED. HALTED exits only by rst.
//    Redirect in DRAIN: still flushes, state stays DRAIN. Redirect in HALTED: ignored.
//  - Issue: imem_req_valid = (state==RUN) && (outstanding+count < BUF_DEPTH), registered
//    terms only (no comb path from inputs). imem_req_addr = pc. Request need not be held
//    stable; memory samples valid&ready each cycle. On accept: pc <= pc+4 (mod 2^32),
//    outstanding++.
//  - Response: outstanding-- each imem_rsp_valid. If drop_cnt>0: discard, drop_cnt--.
//    Else push {pc_tag, data}; pc_tag from an internal in-order PC queue of issued addresses.
//    Credit rule guarantees no push when full; push-while-full is an assertion failure.
//  - Decode side: ir_valid = !empty; ir/ir_pc = head, registered. Pop on ir_valid&&ir_ready.
//    Push+pop same cycle allowed at any occupancy. Min latency accept->ir_valid = rsp lat + 1.
//  - Redirect (priority rst > redirect > halt > normal): same-cycle buffer flush (ir_valid=0
//    next cycle, pushes/pops this cycle discarded), pc <= {redirect_pc[31:2],2'b00},
//    drop_cnt <= outstanding after this cycle's accept/response (request accepted in the
//    redirect cycle is dropped too; response arriving that cycle is dropped and not counted).
//    First request to new PC issues the cycle after redirect.
//  - Halt: sampled in RUN -> DRAIN; no new requests from next cycle. Buffered and returning
//    words still delivered unless flushed. halted=1 in HALTED only.
//  - Outputs hold value while ir_valid&&!ir_ready (no change to head without pop/flush).
// TESTING
//  1 Reset, memory ready always, 1-cycle rsp: requests 0x0,0x4,0x8...; ir_pc sequence
//    0x0,0x4,0x8 with ir=mem word, one instr/cycle after fill; never >2 outstanding.
//  2 ir_ready=0 for 10 cycles: buffer fills to 2, imem_req_valid=0 once credits gone, ir/ir_pc
//    stable; release ready -> no lost or duplicated instruction.
//  3 Redirect to 0x103 with 2 responses in flight: both dropped, next request addr 0x100,
//    next ir_pc=0x100; no stale instruction reaches decode.
//  4 Redirect same cycle as imem_rsp_valid and a request accept: rsp dropped, accepted
//    request's rsp also dropped, drop_cnt returns to 0.
//  5 halt at pc 0x20 with 1 outstanding: no new request, outstanding word delivered,
//    halted=1 when outstanding=0; later redirect ignored; rst resumes at RESET_PC.
//  6 rst asserted mid-stream with full buffer: next cycle ir_valid=0, imem_req_valid=0,
//    then fetch restarts at RESET_PC; late memory responses after rst are not pushed.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, redirect/halt control and the
// decode-side valid/ready handshake.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, halt,
        output ir_valid, ir, ir_pc,
        input  ir_ready,
        output halted
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, halt,
        input  ir_valid, ir, ir_pc,
        output ir_ready,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads, tags returns from an
// in-order PC queue and buffers them for decode; redirect flushes, halt drains then stops.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_rst_q;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_out, r_drop, r_cnt, w_out_nxt;
    logic [PW-1:0] r_rd, r_wr, r_trd, r_twr;
    logic [31:0]   r_data [BUF_DEPTH];
    logic [31:0]   r_dpc  [BUF_DEPTH];
    logic [31:0]   r_tag  [BUF_DEPTH];
    logic [31:0]   w_redir_pc;
    logic          w_req_valid, w_acc, w_rsp, w_redir, w_push, w_pop, w_ir_valid;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_redir_pc = bus.redirect_pc & ~32'h3;
    assign w_redir    = bus.redirect_valid && (r_state != S_HALTED);
    assign w_acc      = w_req_valid && bus.imem_req_ready;
    // a response with nothing outstanding belongs to a request issued before reset
    assign w_rsp      = bus.imem_rsp_valid && (r_out != '0);
    assign w_push     = w_rsp && (r_drop == '0) && !w_redir;
    assign w_ir_valid = (r_cnt != '0);
    assign w_pop      = w_ir_valid && bus.ir_ready && !w_redir;
    assign w_out_nxt  = r_out + CW'(w_acc) - CW'(w_rsp);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (bus.halt && !w_redir) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_out == '0)          w_state_nxt = S_HALTED;
            default: w_state_nxt = r_state;
        endcase
    end

    // r_rst_q keeps the request line low for the cycle following a reset edge
    always_comb begin
        w_req_valid = (r_state == S_RUN) && !r_rst_q &&
                      (({1'b0, r_out} + {1'b0, r_cnt}) < (CW + 1)'(BUF_DEPTH));
        bus.halted  = (r_state == S_HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_q <= 1'b1;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_trd   <= '0;
            r_twr   <= '0;
        end else begin
            r_rst_q <= 1'b0;
            r_out   <= w_out_nxt;
            if (w_acc) r_twr <= f_inc(r_twr);
            if (w_rsp) r_trd <= f_inc(r_trd);
            if (w_redir) begin
                r_pc   <= w_redir_pc;
                // this cycle's response is already netted out of w_out_nxt
                r_drop <= w_out_nxt;
                r_cnt  <= '0;
                r_rd   <= '0;
                r_wr   <= '0;
            end else begin
                if (w_acc) r_pc <= r_pc + 32'd4;
                if (w_rsp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
                if (w_push) r_wr <= f_inc(r_wr);
                if (w_pop)  r_rd <= f_inc(r_rd);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_tag[r_twr] <= r_pc;
        if (w_push) begin
            r_data[r_wr] <= bus.imem_rsp_data;
            r_dpc[r_wr]  <= r_tag[r_trd];
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.ir_valid       = w_ir_valid;
    assign bus.ir             = w_ir_valid ? r_data[r_rd] : '0;
    assign bus.ir_pc          = w_ir_valid ? r_dpc[r_rd]  : '0;

    always_ff @(posedge clk) begin
        if (!rst) assert (!(w_push && (r_cnt == CW'(BUF_DEPTH))));
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model, scoreboard of {pc, word} queued
// on each accept, a table of redirect vectors and hand-written halt/reset sequences.
module tb_fetch_unit;
    localparam int          BD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(BD)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        logic [31:0] rpc; int arm; int lat; bit rrand; int irdy; logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend [$];
    exp_t        expq [$];
    int          n_tests = 0, n_fail = 0, cyc = 0, pops = 0;
    int          lat = 1, irdy_mode = 1, redir_arm = 0;
    bit          rdy_rand = 0, rst_d = 0, halt_arm = 0, halt_fired = 0, redir_fired = 0;
    bit          flush_chk = 0, hold_v = 0, drain_chk = 0, want_first = 0;
    logic [31:0] redir_pc = '0, tb_pc = RPC, hold_ir, hold_pc, first_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // one cycle: observe outputs at the negedge, model memory/decode, drive next inputs
    task automatic cycle();
        bit rdy, irdy, rsp_v, acc, redir, halt;
        int psz;
        logic [31:0] rsp_d;
        pend_t p;
        exp_t  e;
        cyc++;
        psz = pend.size();
        if (flush_chk) chk("flush_ir_valid", bus.ir_valid, 0);
        flush_chk = 0;
        if (hold_v) begin
            chk("hold_valid", bus.ir_valid, 1);
            chk("hold_ir", bus.ir, hold_ir);
            chk("hold_ir_pc", bus.ir_pc, hold_pc);
        end
        if (drain_chk) chk("no_req_after_halt", bus.imem_req_valid, 0);
        chk("outstanding_le_depth", psz <= BD, 1);
        rsp_v = 0;
        rsp_d = '0;
        if (psz > 0 && pend[0].due <= cyc) begin
            rsp_v = 1;
            rsp_d = memf(pend[0].addr);
            pend.delete(0);
        end
        rdy = rst_d ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        acc = bus.imem_req_valid && rdy;
        redir = !rst_d && ((redir_arm == 1) || (redir_arm == 2 && rsp_v && acc) ||
                           (redir_arm == 3 && psz == BD));
        if (redir) begin redir_arm = 0; redir_fired = 1; end
        halt = !rst_d && halt_arm && (bus.imem_req_addr == 32'h20);
        if (halt) begin halt_arm = 0; halt_fired = 1; end
        irdy = (irdy_mode == 2) ? 1'($urandom_range(0, 1)) : (irdy_mode == 1);
        if (acc) begin
            chk("req_addr", bus.imem_req_addr, tb_pc);
            p.addr = bus.imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            e.pc   = tb_pc;
            e.data = memf(tb_pc);
            expq.push_back(e);
            tb_pc += 32'd4;
        end
        if (bus.ir_valid && irdy && !redir && !rst_d) begin
            if (expq.size() == 0) chk("spurious_ir_valid", bus.ir_valid, 0);
            else begin
                chk("ir_pc", bus.ir_pc, expq[0].pc);
                chk("ir", bus.ir, expq[0].data);
                expq.delete(0);
                pops++;
                if (want_first) begin first_pc = bus.ir_pc; want_first = 0; end
            end
        end
        hold_v  = bus.ir_valid && !irdy && !redir && !rst_d;
        hold_ir = bus.ir;
        hold_pc = bus.ir_pc;
        if (redir) begin
            expq.delete();
            tb_pc = redir_pc & ~32'h3;
            flush_chk = 1;
            want_first = 1;
        end
        if (halt && !redir) drain_chk = 1;
        if (rst_d) begin
            expq.delete();
            tb_pc = RPC;
            drain_chk = 0;
            hold_v = 0;
        end
        rst                = rst_d;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = rsp_d;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        bus.halt           = halt;
        bus.ir_ready       = irdy;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_d = 1;
        redir_arm = 0;
        halt_arm = 0;
        repeat (n) cycle();
        rst_d = 0;
    endtask

    initial begin
        vec_t vt [4];
        vt[0] = '{32'h0000_0103, 3, 2, 1'b0, 1, 32'h0000_0100};
        vt[1] = '{32'h0000_0043, 2, 1, 1'b0, 1, 32'h0000_0040};
        vt[2] = '{32'h0000_0002, 1, 2, 1'b1, 2, 32'h0000_0000};
        vt[3] = '{32'hFFFF_FFF6, 1, 1, 1'b0, 1, 32'hFFFF_FFF4};

        rst = 1'b1;
        bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt = 0; bus.ir_ready = 0;
        @(negedge clk);

        // streaming from reset, 1-cycle memory
        lat = 1; rdy_rand = 0; irdy_mode = 1;
        do_reset(2);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_ir_valid", bus.ir_valid, 0);
        chk("rst_ir", bus.ir, 0);
        chk("rst_ir_pc", bus.ir_pc, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_req_addr", bus.imem_req_addr, RPC);
        pops = 0;
        repeat (30) cycle();
        chk("stream_progress", pops >= 10, 1);

        // decode stalls: buffer fills, credits run out, head holds
        do_reset(1);
        irdy_mode = 0;
        repeat (10) cycle();
        chk("stall_ir_valid", bus.ir_valid, 1);
        chk("stall_req_valid", bus.imem_req_valid, 0);
        chk("stall_buffered", expq.size(), 2);
        chk("stall_inflight", pend.size(), 0);
        chk("stall_head_pc", bus.ir_pc, RPC);
        irdy_mode = 1; pops = 0;
        repeat (15) cycle();
        chk("stall_release", pops >= 6, 1);

        // redirect vectors
        for (int i = 0; i < 4; i++) begin
            do_reset(1);
            lat = vt[i].lat; rdy_rand = vt[i].rrand; irdy_mode = vt[i].irdy;
            redir_pc = vt[i].rpc; redir_fired = 0; first_pc = 32'h1;
            redir_arm = vt[i].arm;
            for (int k = 0; k < 40 && !redir_fired; k++) cycle();
            chk("redir_fired", redir_fired, 1);
            chk("redir_next_addr", bus.imem_req_addr, vt[i].exp_pc);
            repeat (40) cycle();
            chk("redir_first_ir_pc", first_pc, vt[i].exp_pc);
        end
        rdy_rand = 0;

        // halt at pc 0x20, drain, ignore redirect, resume on reset
        do_reset(1);
        lat = 1; irdy_mode = 1; halt_fired = 0; halt_arm = 1;
        for (int k = 0; k < 40 && !halt_fired; k++) cycle();
        chk("halt_fired", halt_fired, 1);
        for (int k = 0; k < 30 && !bus.halted; k++) cycle();
        chk("halted", bus.halted, 1);
        repeat (2) cycle();
        chk("halt_delivered", expq.size(), 0);
        chk("halt_inflight", pend.size(), 0);
        chk("halt_ir_valid", bus.ir_valid, 0);
        redir_pc = 32'h0000_0400; redir_arm = 1;
        repeat (3) cycle();
        chk("halt_redir_halted", bus.halted, 1);
        chk("halt_redir_req", bus.imem_req_valid, 0);
        chk("halt_redir_pc", bus.imem_req_addr == 32'h400, 0);
        do_reset(1);
        chk("resume_halted", bus.halted, 0);
        chk("resume_addr", bus.imem_req_addr, RPC);
        pops = 0;
        repeat (15) cycle();
        chk("resume_progress", pops >= 5, 1);

        // reset with a full buffer, then with responses still in flight
        lat = 2; irdy_mode = 0;
        repeat (8) cycle();
        chk("full_ir_valid", bus.ir_valid, 1);
        do_reset(1);
        chk("rst_full_ir_valid", bus.ir_valid, 0);
        chk("rst_full_req_valid", bus.imem_req_valid, 0);
        lat = 3; irdy_mode = 1;
        repeat (12) cycle();
        do_reset(1);
        chk("rst_late_ir_valid", bus.ir_valid, 0);
        pops = 0;
        repeat (25) cycle();
        chk("rst_late_progress", pops >= 4, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
